bip2_io_unit: RTL and testbench

Memory-mapped I/O unit on the BIP2 processor data bus, downstream of the core's data address, write-data and write-strobe outputs. It decodes an 8-word I/O window and provides:
- a 16-bit output port;
- a synchronized 16-bit input port with rising-edge capture;
- a prescaled 16-bit timer with compare match.

Its read data is muxed with data memory by the top level into the core's `data_in`.

---
 rtl/bip2_io_unit.sv | 127 ++++++++++++
 tb/tb_bip2_io_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bip2_io_unit.sv
// BIP2 memory-mapped I/O unit: output port, synchronized input port with
// rising-edge capture, and a prescaled timer with compare match.
`timescale 1ns/1ps
module bip2_io_unit #(
   parameter int unsigned OPERAND_ADDRESS_WIDTH  = 11,
   parameter int unsigned INSTRUCTION_DATA_WIDTH = 16,
   parameter logic [OPERAND_ADDRESS_WIDTH-1:0] IO_BASE = 11'h7F8
) (
   input  logic                              clock_in,
   input  logic                              reset_in,
   input  logic [OPERAND_ADDRESS_WIDTH-1:0]  data_address_in,
   input  logic [INSTRUCTION_DATA_WIDTH-1:0] data_in,
   input  logic                              data_wr_in,
   output logic [INSTRUCTION_DATA_WIDTH-1:0] data_out,
   output logic                              io_select_out,
   input  logic [INSTRUCTION_DATA_WIDTH-1:0] port_in,
   output logic [INSTRUCTION_DATA_WIDTH-1:0] port_out,
   output logic                              timer_match_out
);

   localparam int unsigned A  = OPERAND_ADDRESS_WIDTH;
   localparam int unsigned W  = INSTRUCTION_DATA_WIDTH;
   localparam int unsigned PW = W - 8;

   logic          select;
   logic [2:0]    offset;
   logic [7:0]    wr_sel;

   logic [W-1:0]  sync1, sync2, prev, edge_flags, edge_next;
   logic          en, reload, match;
   logic [PW-1:0] presc, psc;
   logic [W-1:0]  cmp, cnt;

   logic          en_next, reload_next, match_next, match_set, tick;
   logic [PW-1:0] presc_next, psc_next;
   logic [W-1:0]  cnt_next;

   // Address decode: one-hot write select per register offset
   assign select          = data_address_in[A-1:3] == IO_BASE[A-1:3];
   assign offset          = data_address_in[2:0];
   assign wr_sel          = (data_wr_in && select) ? (8'(1) << offset) : 8'(0);
   assign io_select_out   = select;
   assign timer_match_out = match;
   assign tick            = en && (psc == presc);

   // Timer and flag next-state; CPU writes to CNT/CTRL override the timer update
   always_comb begin
      psc_next    = psc;
      cnt_next    = cnt;
      en_next     = en;
      reload_next = reload;
      presc_next  = presc;
      match_set   = 1'b0;
      if (en) begin
         psc_next = tick ? PW'(0) : psc + PW'(1);
         if (tick) begin
            if (cnt == cmp) begin
               match_set = 1'b1;
               if (reload) cnt_next = W'(0);
               else        en_next  = 1'b0;
            end else begin
               cnt_next = cnt + W'(1);
            end
         end
      end
      if (wr_sel[5]) begin
         cnt_next  = data_in;
         psc_next  = PW'(0);
         match_set = 1'b0;
      end
      if (wr_sel[3]) begin
         en_next     = data_in[0];
         reload_next = data_in[1];
         presc_next  = data_in[W-1:8];
      end
      match_next = (match & ~(wr_sel[6] & data_in[0])) | match_set;
      edge_next  = (edge_flags & ~(wr_sel[2] ? data_in : W'(0))) | (sync2 & ~prev);
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         port_out   <= '0;
         sync1      <= '0;
         sync2      <= '0;
         prev       <= '0;
         edge_flags <= '0;
         en         <= 1'b0;
         reload     <= 1'b0;
         presc      <= '0;
         psc        <= '0;
         cmp        <= '0;
         cnt        <= '0;
         match      <= 1'b0;
      end else begin
         if (wr_sel[0]) port_out <= data_in;
         if (wr_sel[4]) cmp      <= data_in;
         sync1      <= port_in;
         sync2      <= sync1;
         prev       <= sync2;
         edge_flags <= edge_next;
         en         <= en_next;
         reload     <= reload_next;
         presc      <= presc_next;
         psc        <= psc_next;
         cnt        <= cnt_next;
         match      <= match_next;
      end
   end

   // Combinational read mux; zero outside the window
   always_comb begin
      data_out = '0;
      if (select) begin
         case (offset)
            3'd0:    data_out = port_out;
            3'd1:    data_out = sync2;
            3'd2:    data_out = edge_flags;
            3'd3:    data_out = {presc, 6'b0, reload, en};
            3'd4:    data_out = cmp;
            3'd5:    data_out = cnt;
            3'd6:    data_out = W'(match);
            default: data_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_bip2_io_unit.sv
// Self-checking bench for bip2_io_unit: register access, input sync/edge
// capture, timer reload/one-shot/wrap, collision priorities and async reset.
`timescale 1ns/1ps
module tb_bip2_io_unit;

   localparam int unsigned AW = 11;
   localparam int unsigned W  = 16;
   localparam logic [AW-1:0] BASE = 11'h7F8;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] addr;
   logic [W-1:0]  din, dout, pin, pout;
   logic          we, sel, match;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];
   string        tag_q[$];

   bip2_io_unit dut (
      .clock_in        (clk),
      .reset_in        (rst),
      .data_address_in (addr),
      .data_in         (din),
      .data_wr_in      (we),
      .data_out        (dout),
      .io_select_out   (sel),
      .port_in         (pin),
      .port_out        (pout),
      .timer_match_out (match)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Bus write: driven at a falling edge, sampled at the next rising edge
   task automatic wr(input int off, input logic [W-1:0] v);
      addr = BASE | AW'(off);
      din  = v;
      we   = 1'b1;
      @(negedge clk);
      we   = 1'b0;
   endtask

   // Combinational read: expectation queued, then compared once data_out settles
   task automatic peek(input int off, input logic [W-1:0] exp, input string tag);
      addr = BASE | AW'(off);
      we   = 1'b0;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      #1;
      check(tag_q.pop_front(), dout, exp_q.pop_front());
   endtask

   task automatic rd(input int off, input logic [W-1:0] exp, input string tag);
      peek(off, exp, tag);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; addr = BASE; din = '0; we = 1'b0; pin = '0;
      @(negedge clk);
      check("rst_pout", pout, 16'h0000);
      check("rst_match", W'(match), 16'h0000);
      peek(0, 16'h0000, "rst_rd");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Plain registers, reserved/RO offsets, window decode
      wr(0, 16'hA5C3);
      check("pout", pout, 16'hA5C3);
      rd(0, 16'hA5C3, "rd_pout");
      rd(7, 16'h0000, "rd_rsv");
      wr(7, 16'h1234);
      rd(7, 16'h0000, "rsv_wr");
      wr(1, 16'hFFFF);
      rd(1, 16'h0000, "pin_ro");
      addr = 11'h010; #1;
      check("sel_off", W'(sel), 16'h0000);
      check("unsel_rd", dout, 16'h0000);
      addr = BASE; #1;
      check("sel_on", W'(sel), 16'h0001);
      @(negedge clk);

      // Input synchronizer and edge capture
      pin = 16'h0081;
      @(negedge clk);
      rd(1, 16'h0000, "pin_e1");
      peek(1, 16'h0081, "pin_e2");
      peek(2, 16'h0000, "edge_e2");
      @(negedge clk);
      peek(2, 16'h0081, "edge_e3");
      @(negedge clk);
      wr(2, 16'h0001);
      rd(2, 16'h0080, "edge_w1c");
      pin = 16'h0080;
      repeat (4) @(negedge clk);
      pin = 16'h0081;
      repeat (2) @(negedge clk);
      wr(2, 16'h0001);
      rd(2, 16'h0081, "edge_set_wins");
      wr(2, 16'hFFFF);
      rd(2, 16'h0000, "edge_clr_all");

      // Periodic timer: CMP=3, PRESC=1
      wr(4, 3);
      wr(5, 0);
      wr(3, 16'h0103);
      for (int j = 0; j <= 24; j++) begin
         if (j == 0) peek(3, 16'h0103, "ctrl_rd");
         peek(5, W'((j / 2) % 4), "cnt_reload");
         check("match_reload", W'(match), W'(j >= 8));
         @(negedge clk);
      end
      wr(3, 0);
      wr(6, 1);
      rd(6, 16'h0000, "match_clr");
      rd(3, 16'h0000, "ctrl_off");

      // One-shot: CMP=2, PRESC=0
      wr(5, 0);
      wr(4, 2);
      wr(3, 16'h0001);
      for (int j = 0; j <= 6; j++) begin
         peek(5, W'((j < 2) ? j : 2), "cnt_oneshot");
         check("match_oneshot", W'(match), W'(j >= 3));
         @(negedge clk);
      end
      rd(3, 16'h0000, "oneshot_en");
      wr(6, 1);
      repeat (5) @(negedge clk);
      peek(5, 16'h0002, "oneshot_hold");
      check("oneshot_nomatch", W'(match), 16'h0000);
      @(negedge clk);

      // Counter wrap, then MATCH clear colliding with a new match
      wr(4, 5);
      wr(5, 16'hFFFF);
      wr(3, 16'h0001);
      for (int j = 0; j <= 5; j++) begin
         peek(5, W'(j - 1), "cnt_wrap");
         check("match_wrap", W'(match), 16'h0000);
         @(negedge clk);
      end
      wr(6, 1);
      peek(6, 16'h0001, "match_set_wins");
      check("match_pin_wins", W'(match), 16'h0001);
      peek(5, 16'h0005, "wrap_hold");
      @(negedge clk);

      // Asynchronous reset mid-count
      wr(0, 16'hFFFF);
      wr(5, 0);
      wr(4, 100);
      wr(3, 16'h0001);
      repeat (3) @(negedge clk);
      check("pre_rst_pout", pout, 16'hFFFF);
      check("pre_rst_match", W'(match), 16'h0001);
      #1 rst = 1'b1;
      #1;
      check("arst_pout", pout, 16'h0000);
      check("arst_match", W'(match), 16'h0000);
      peek(5, 16'h0000, "arst_cnt");
      addr = 11'h010; #1;
      check("arst_unsel", dout, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rd(5, 16'h0000, "post_rst_cnt");
      rd(3, 16'h0000, "post_rst_ctrl");
      check("post_rst_match", W'(match), 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
